elelock_ctrl: RTL

//  Multi-digit code-entry sequencer for the electronic lock. Turns raw 10-key presses into

---
 rtl/elelock_pkg.sv | 30 +++
 rtl/elelock_if.sv | 27 ++
 rtl/elelock_keyscan.sv | 34 +++
 rtl/elelock_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/elelock_pkg.sv
// Shared types and helpers for the electronic-lock code-entry sequencer.
package elelock_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    // Wide enough for the largest supported code (8 digits); sliced to size by users.
    localparam logic [31:0] CODE_BLANK = 32'hFFFF_FFFF;

    // Returns {valid, bcd}; valid only when exactly one key is down.
    function automatic logic [4:0] keyenc(input logic [9:0] keys);
        logic [3:0]  digit;
        int unsigned hits;
        digit = 4'd0;
        hits  = 0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                digit = 4'(i);
                hits++;
            end
        end
        return {(hits == 1), digit};
    endfunction

endpackage

// File: rtl/elelock_if.sv
// Keypad / door sensor / actuator signal bundle for the lock controller.
interface elelock_if;
    logic [9:0] tenkey;
    logic       close;
    logic       lock;
    logic       alarm;
    logic       err;
    logic [3:0] digit_cnt;

    modport master (
        output tenkey,
        output close,
        input  lock,
        input  alarm,
        input  err,
        input  digit_cnt
    );

    modport slave (
        input  tenkey,
        input  close,
        output lock,
        output alarm,
        output err,
        output digit_cnt
    );
endinterface

// File: rtl/elelock_keyscan.sv
// Turns keypad levels into single-cycle digit events (press from all-released, exactly one key).
module elelock_keyscan
    import elelock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] tenkey,
    output logic       key_evt,
    output logic [3:0] key_digit
);

    logic [9:0] tenkey_q;
    logic       key_evt_q;
    logic [3:0] key_digit_q;
    logic [4:0] enc;

    assign enc = keyenc(tenkey);

    always_ff @(posedge clk) begin
        if (reset) begin
            tenkey_q    <= '0;
            key_evt_q   <= 1'b0;
            key_digit_q <= 4'd0;
        end else begin
            tenkey_q    <= tenkey;
            key_evt_q   <= (tenkey_q == '0) && enc[4];
            key_digit_q <= enc[3:0];
        end
    end

    assign key_evt   = key_evt_q;
    assign key_digit = key_digit_q;

endmodule

// File: rtl/elelock_ctrl.sv
// Code-entry sequencer: collects digits, checks against SECRET, drives lock/alarm/err
// with entry timeout, fail counting and timed alarm lockout.
module elelock_ctrl #(
    parameter int unsigned          DIGITS      = 4,
    parameter logic [DIGITS*4-1:0]  SECRET      = 16'h1234,
    parameter int unsigned          MAX_FAIL    = 3,
    parameter int unsigned          TIMEOUT_CYC = 500,
    parameter int unsigned          LOCKOUT_CYC = 1000
) (
    input logic       clk,
    input logic       reset,
    elelock_if.slave  bus
);
    import elelock_pkg::*;

    localparam int unsigned CODE_W = DIGITS * 4;
    localparam int unsigned CW     = $clog2(DIGITS + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned LW     = $clog2(LOCKOUT_CYC + 1);
    localparam int unsigned FW     = $clog2(MAX_FAIL + 1);

    localparam logic [CODE_W-1:0] BLANK     = CODE_BLANK[CODE_W-1:0];
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DIGITS - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0]     LOCK_LAST = LW'(LOCKOUT_CYC - 1);
    localparam logic [FW-1:0]     FAIL_MAX  = FW'(MAX_FAIL);

    logic             key_evt;
    logic [3:0]       key_digit;

    state_t           state_q,    state_d;
    logic [CODE_W-1:0] code_q,    code_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [TW-1:0]    timer_q,    timer_d;
    logic [LW-1:0]    lo_timer_q, lo_timer_d;
    logic [FW-1:0]    fail_q,     fail_d;
    logic             lock_q,     lock_d;
    logic             alarm_q,    alarm_d;
    logic             err_q,      err_d;

    logic [CODE_W-1:0] code_shift;
    logic [FW-1:0]     fail_inc;

    elelock_keyscan u_keyscan (
        .clk       (clk),
        .reset     (reset),
        .tenkey    (bus.tenkey),
        .key_evt   (key_evt),
        .key_digit (key_digit)
    );

    assign code_shift = (code_q << 4) | CODE_W'(key_digit);
    assign fail_inc   = fail_q + FW'(1);

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        lo_timer_d = lo_timer_q;
        fail_d     = fail_q;
        err_d      = 1'b0;

        case (state_q)
            LOCKED: begin
                if (key_evt) begin
                    code_d  = code_shift;
                    cnt_d   = CW'(1);
                    timer_d = '0;
                    state_d = (DIGITS == 1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                // close beats a same-cycle digit; a digit beats a same-cycle timeout
                if (bus.close) begin
                    code_d  = BLANK;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = LOCKED;
                end else if (key_evt) begin
                    code_d  = code_shift;
                    cnt_d   = cnt_q + CW'(1);
                    timer_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = CHECK;
                    end
                end else if (timer_q == TMO_LAST) begin
                    code_d  = BLANK;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = LOCKED;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (code_q == SECRET) begin
                    fail_d  = '0;
                    state_d = OPEN;
                end else begin
                    err_d      = 1'b1;
                    fail_d     = fail_inc;
                    code_d     = BLANK;
                    cnt_d      = '0;
                    lo_timer_d = '0;
                    state_d    = (fail_inc == FAIL_MAX) ? LOCKOUT : LOCKED;
                end
            end
            OPEN: begin
                if (bus.close) begin
                    code_d  = BLANK;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                if (lo_timer_q == LOCK_LAST) begin
                    lo_timer_d = '0;
                    fail_d     = '0;
                    state_d    = LOCKED;
                end else begin
                    lo_timer_d = lo_timer_q + LW'(1);
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase

        lock_d  = (state_d != OPEN);
        alarm_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOCKED;
            code_q     <= BLANK;
            cnt_q      <= '0;
            timer_q    <= '0;
            lo_timer_q <= '0;
            fail_q     <= '0;
            lock_q     <= 1'b1;
            alarm_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            lo_timer_q <= lo_timer_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
            alarm_q    <= alarm_d;
            err_q      <= err_d;
        end
    end

    assign bus.lock      = lock_q;
    assign bus.alarm     = alarm_q;
    assign bus.err       = err_q;
    assign bus.digit_cnt = 4'(cnt_q);

endmodule
